// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: decode-side control, instruction memory port, IF/ID outputs.
// Master is the fetch stage; slave is the surrounding pipeline and memory.
// Pure wiring, no state; widths follow ISIZE/DSIZE.
interface fetch_if #(
  parameter int ISIZE = 16,
  parameter int DSIZE = 16
);
  logic             stall;
  logic             branch_taken;
  logic [ISIZE-1:0] branch_target;
  logic [DSIZE-1:0] imem_data;
  logic [ISIZE-1:0] imem_addr;
  logic             imem_read;
  logic [DSIZE-1:0] ifid_instr;
  logic [ISIZE-1:0] ifid_pc;
  logic [ISIZE-1:0] ifid_pc_plus1;
  logic             ifid_valid;
  logic [15:0]      fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, imem_read, ifid_instr, ifid_pc, ifid_pc_plus1,
           ifid_valid, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, imem_read, ifid_instr, ifid_pc, ifid_pc_plus1,
           ifid_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem, loads IF/ID with instr/pc/pc+1.
// Latency: first instruction valid in IF/ID two edges after reset release; then 1/cycle.
// Backpressure: stall holds everything and re-requests the in-flight word; branch wins over stall.
module fetch_stage #(
  parameter int               ISIZE    = 16,
  parameter int               DSIZE    = 16,
  parameter logic [ISIZE-1:0] RESET_PC = '0
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master bus
);

  localparam logic [ISIZE-1:0] PC_ONE  = ISIZE'(1);
  localparam logic [15:0]      CNT_MAX = 16'hFFFF;

  logic [ISIZE-1:0] pc;
  logic [ISIZE-1:0] inflight_pc;
  logic             inflight_valid;

  // Memory is always reading once out of reset.
  assign bus.imem_read = rst;

  // Address select: redirect first, then re-request the in-flight word on stall
  // so its data is presented again on release, otherwise the next sequential PC.
  always_comb begin
    bus.imem_addr = pc;
    if (!rst) begin
      bus.imem_addr = RESET_PC;
    end else if (bus.branch_taken) begin
      bus.imem_addr = bus.branch_target;
    end else if (bus.stall) begin
      bus.imem_addr = inflight_pc;
    end
  end

  // PC, in-flight tracking, IF/ID register and delivered-instruction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc                <= RESET_PC;
      inflight_pc       <= RESET_PC;
      inflight_valid    <= 1'b0;
      bus.ifid_instr    <= '0;
      bus.ifid_pc       <= '0;
      bus.ifid_pc_plus1 <= '0;
      bus.ifid_valid    <= 1'b0;
      bus.fetch_count   <= '0;
    end else if (bus.branch_taken) begin
      // The word landing this cycle is wrong-path; insert one bubble.
      bus.ifid_valid <= 1'b0;
      inflight_pc    <= bus.branch_target;
      inflight_valid <= 1'b1;
      pc             <= bus.branch_target + PC_ONE;
    end else if (!bus.stall) begin
      bus.ifid_instr    <= bus.imem_data;
      bus.ifid_pc       <= inflight_pc;
      bus.ifid_pc_plus1 <= inflight_pc + PC_ONE;
      bus.ifid_valid    <= inflight_valid;
      inflight_pc       <= pc;
      inflight_valid    <= 1'b1;
      pc                <= pc + PC_ONE;
      if (inflight_valid && (bus.fetch_count != CNT_MAX)) begin
        bus.fetch_count <= bus.fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for run/stall/branch, hand sequences
// for the wrap-around/async-reset case and counter saturation.
module tb_fetch_stage;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic rst2 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_if #(.ISIZE(16), .DSIZE(16)) bus1 ();
  fetch_if #(.ISIZE(16), .DSIZE(16)) bus2 ();

  fetch_stage #(.ISIZE(16), .DSIZE(16), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  fetch_stage #(.ISIZE(16), .DSIZE(16), .RESET_PC(16'hFFFE)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  // Instruction memory model with registered address (one per DUT).
  logic [15:0] mem [65536];
  logic [15:0] addr_q1 = 16'h0000;
  logic [15:0] addr_q2 = 16'h0000;

  always @(posedge clk) if (bus1.imem_read) addr_q1 <= bus1.imem_addr;
  always @(posedge clk) if (bus2.imem_read) addr_q2 <= bus2.imem_addr;

  assign bus1.imem_data = mem[addr_q1];
  assign bus2.imem_data = mem[addr_q2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_first;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] e_addr;
    logic        e_v;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  task automatic edge_chk2(input string name, input logic v, input logic [15:0] instr,
                           input logic [15:0] pc, input logic [15:0] pc1,
                           input logic [15:0] cnt);
    @(posedge clk); #1;
    chk({name, ".valid"}, {31'd0, bus2.ifid_valid}, {31'd0, v});
    if (v) begin
      chk({name, ".instr"}, {16'd0, bus2.ifid_instr}, {16'd0, instr});
      chk({name, ".pc"}, {16'd0, bus2.ifid_pc}, {16'd0, pc});
      chk({name, ".pc1"}, {16'd0, bus2.ifid_pc_plus1}, {16'd0, pc1});
    end
    chk({name, ".cnt"}, {16'd0, bus2.fetch_count}, {16'd0, cnt});
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'(a) + 16'h8000;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

    //           rst  stl  br   tgt       addr      v    instr     pc        cnt
    vt[0]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,16'h0000,16'd0};
    vt[1]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0001,1'b1,16'h1111,16'h0000,16'd1};
    vt[2]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0002,1'b1,16'h2222,16'h0001,16'd2};
    vt[3]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0003,1'b1,16'h3333,16'h0002,16'd3};
    vt[4]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0004,1'b1,16'h4444,16'h0003,16'd4};
    vt[5]  = '{1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,16'h0000,16'd0};
    vt[6]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0001,1'b1,16'h1111,16'h0000,16'd1};
    vt[7]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0002,1'b1,16'h2222,16'h0001,16'd2};
    vt[8]  = '{1'b0,1'b1,1'b0,16'h0000,16'h0002,1'b1,16'h2222,16'h0001,16'd2};
    vt[9]  = '{1'b0,1'b1,1'b0,16'h0000,16'h0002,1'b1,16'h2222,16'h0001,16'd2};
    vt[10] = '{1'b0,1'b1,1'b0,16'h0000,16'h0002,1'b1,16'h2222,16'h0001,16'd2};
    vt[11] = '{1'b0,1'b0,1'b0,16'h0000,16'h0003,1'b1,16'h3333,16'h0002,16'd3};
    vt[12] = '{1'b0,1'b0,1'b1,16'h0040,16'h0040,1'b0,16'h0000,16'h0000,16'd3};
    vt[13] = '{1'b0,1'b0,1'b0,16'h0000,16'h0041,1'b1,16'h8040,16'h0040,16'd4};
    vt[14] = '{1'b0,1'b0,1'b0,16'h0000,16'h0042,1'b1,16'h8041,16'h0041,16'd5};
    vt[15] = '{1'b0,1'b1,1'b1,16'h0010,16'h0010,1'b0,16'h0000,16'h0000,16'd5};
    vt[16] = '{1'b0,1'b0,1'b0,16'h0000,16'h0011,1'b1,16'h8010,16'h0010,16'd6};
    vt[17] = '{1'b0,1'b0,1'b1,16'h0011,16'h0011,1'b0,16'h0000,16'h0000,16'd6};
    vt[18] = '{1'b0,1'b0,1'b0,16'h0000,16'h0012,1'b1,16'h8011,16'h0011,16'd7};
    vt[19] = '{1'b0,1'b0,1'b0,16'h0000,16'h0013,1'b1,16'h8012,16'h0012,16'd8};
    vt[20] = '{1'b0,1'b1,1'b0,16'h0000,16'h0013,1'b1,16'h8012,16'h0012,16'd8};
    vt[21] = '{1'b0,1'b0,1'b1,16'h0020,16'h0020,1'b0,16'h0000,16'h0000,16'd8};
    vt[22] = '{1'b0,1'b0,1'b0,16'h0000,16'h0021,1'b1,16'h8020,16'h0020,16'd9};

    bus1.stall = 1'b0; bus1.branch_taken = 1'b0; bus1.branch_target = '0;
    bus2.stall = 1'b0; bus2.branch_taken = 1'b0; bus2.branch_target = '0;

    // Reset state of the first instance.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst.read",  {31'd0, bus1.imem_read}, 32'd0);
    chk("rst.addr",  {16'd0, bus1.imem_addr}, 32'h0000);
    chk("rst.valid", {31'd0, bus1.ifid_valid}, 32'd0);
    chk("rst.cnt",   {16'd0, bus1.fetch_count}, 32'd0);
    chk("rst.instr", {16'd0, bus1.ifid_instr}, 32'd0);
    chk("rst.pc1",   {16'd0, bus1.ifid_pc_plus1}, 32'd0);
    rst = 1'b1;

    // Vector table: run, stall, branch, branch+stall, branch to in-flight address.
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      if (vt[i].rst_first) begin
        rst = 1'b0; #1;
        chk($sformatf("v%0d.arst_valid", i), {31'd0, bus1.ifid_valid}, 32'd0);
        chk($sformatf("v%0d.arst_cnt", i), {16'd0, bus1.fetch_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
      end
      bus1.stall = vt[i].stall;
      bus1.branch_taken = vt[i].br;
      bus1.branch_target = vt[i].tgt;
      #1;
      chk($sformatf("v%0d.addr", i), {16'd0, bus1.imem_addr}, {16'd0, vt[i].e_addr});
      chk($sformatf("v%0d.read", i), {31'd0, bus1.imem_read}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d.valid", i), {31'd0, bus1.ifid_valid}, {31'd0, vt[i].e_v});
      if (vt[i].e_v) begin
        chk($sformatf("v%0d.instr", i), {16'd0, bus1.ifid_instr}, {16'd0, vt[i].e_instr});
        chk($sformatf("v%0d.pc", i), {16'd0, bus1.ifid_pc}, {16'd0, vt[i].e_pc});
        chk($sformatf("v%0d.pc1", i), {16'd0, bus1.ifid_pc_plus1},
            {16'd0, vt[i].e_pc + 16'd1});
      end
      chk($sformatf("v%0d.cnt", i), {16'd0, bus1.fetch_count}, {16'd0, vt[i].e_cnt});
    end
    @(negedge clk);
    bus1.stall = 1'b0; bus1.branch_taken = 1'b0;

    // Wrap-around from RESET_PC=FFFE, then asynchronous reset mid-stall.
    #1;
    chk("w.rst_read", {31'd0, bus2.imem_read}, 32'd0);
    chk("w.rst_addr", {16'd0, bus2.imem_addr}, 32'hFFFE);
    rst2 = 1'b1;
    edge_chk2("w.e1", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'd0);
    edge_chk2("w.e2", 1'b1, 16'h7FFE, 16'hFFFE, 16'hFFFF, 16'd1);
    edge_chk2("w.e3", 1'b1, 16'h7FFF, 16'hFFFF, 16'h0000, 16'd2);
    edge_chk2("w.e4", 1'b1, 16'h1111, 16'h0000, 16'h0001, 16'd3);
    @(negedge clk);
    bus2.stall = 1'b1;
    edge_chk2("w.stall", 1'b1, 16'h1111, 16'h0000, 16'h0001, 16'd3);
    #2;
    rst2 = 1'b0;
    #1;
    chk("w.arst_valid", {31'd0, bus2.ifid_valid}, 32'd0);
    chk("w.arst_cnt",   {16'd0, bus2.fetch_count}, 32'd0);
    chk("w.arst_pc",    {16'd0, bus2.ifid_pc}, 32'd0);
    chk("w.arst_addr",  {16'd0, bus2.imem_addr}, 32'hFFFE);
    chk("w.arst_read",  {31'd0, bus2.imem_read}, 32'd0);
    @(negedge clk);
    bus2.branch_taken = 1'b1; bus2.branch_target = 16'h1234;
    #1;
    chk("w.rstbr_addr", {16'd0, bus2.imem_addr}, 32'hFFFE);
    edge_chk2("w.rstbr", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'd0);
    @(negedge clk);
    bus2.stall = 1'b0; bus2.branch_taken = 1'b0;
    rst2 = 1'b1;
    #1;
    chk("w.rel_addr", {16'd0, bus2.imem_addr}, 32'hFFFE);
    edge_chk2("w.r1", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'd0);
    edge_chk2("w.r2", 1'b1, 16'h7FFE, 16'hFFFE, 16'hFFFF, 16'd1);

    // Counter saturation: free-running fetch from a fresh reset.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("sat.pre", {16'd0, bus1.fetch_count}, 32'hFFFE);
    @(posedge clk); #1;
    chk("sat.max", {16'd0, bus1.fetch_count}, 32'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    chk("sat.hold", {16'd0, bus1.fetch_count}, 32'hFFFF);
    chk("sat.valid", {31'd0, bus1.ifid_valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the memory's address and read-enable.
- Absorbs the memory's one-cycle registered-address read latency and loads the IF/ID pipeline register with the instruction, its PC and PC+1.
- Handles decode-stage stalls and branch redirects without losing or duplicating instructions.

Parameters:
- ISIZE, 16, address/PC width in bits (word-addressed, one instruction per address).
- DSIZE, 16, instruction width in bits.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  one clock; reset is asynchronous and active-low.
- stall  input  1  from hazard unit; high = hold PC and IF/ID.
- branch_taken  input  1  redirect request from a later stage.
- branch_target  input  ISIZE  redirect address, valid when branch_taken=1.
- imem_data  input  DSIZE  instruction memory read data, i.e. word at the address the memory registered on the previous edge.
- imem_addr  output  ISIZE  instruction memory address (combinational).
- imem_read  output  1  instruction memory read enable (combinational).
- ifid_instr  output  DSIZE  IF/ID instruction.
- ifid_pc  output  ISIZE  PC of ifid_instr.
- ifid_pc_plus1  output  ISIZE  ifid_pc+1, mod 2^ISIZE.
- ifid_valid  output  1  IF/ID holds a real instruction; 0 = bubble.
- fetch_count  output  16  number of instructions delivered to IF/ID; saturating.

Behaviour:
- Internal state:
  - pc: next address to request.
  - inflight_pc: address the memory registered on the last edge.
  - inflight_valid: data arriving this cycle belongs to the correct path.
  - IF/ID registers.
  - fetch_count.
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, inflight_pc=RESET_PC, inflight_valid=0.
  - ifid_instr=0, ifid_pc=0, ifid_pc_plus1=0, ifid_valid=0, fetch_count=0.
  - imem_read=0 and imem_addr=RESET_PC while rst=0.
- imem_read = rst (1 whenever out of reset).
- imem_addr mux, highest priority first:
  - branch_taken: branch_target.
  - stall: inflight_pc (re-request the in-flight word so the memory output is not lost).
  - otherwise: pc.
- Normal edge (no branch, no stall):
  - IF/ID <= {imem_data, inflight_pc, inflight_pc+1, inflight_valid}.
  - inflight_pc <= pc; inflight_valid <= 1; pc <= pc+1.
- Stall edge (branch_taken=0, stall=1):
  - pc, IF/ID, inflight_pc, inflight_valid and fetch_count all hold.
  - Memory re-reads inflight_pc, so the same word is presented on release.
  - Stall may last any number of cycles.
- Branch edge (branch_taken=1; stall ignored):
  - ifid_valid <= 0; other IF/ID fields don't-care but hold.
  - inflight_pc <= branch_target; inflight_valid <= 1; pc <= branch_target+1.
  - The word arriving on this cycle is discarded.
  - Penalty is exactly one bubble: target instruction reaches IF/ID on the second edge after the branch edge.
- Latency:
  - First instruction (RESET_PC) is in IF/ID with ifid_valid=1 after the second rising edge following rst release.
  - Throughput is one instruction per cycle thereafter.
- fetch_count:
  - Increments on every edge that loads ifid_valid=1 and not on stall edges.
  - Saturates at 16'hFFFF.
- Wrap-around: pc and pc_plus1 wrap 2^ISIZE-1 -> 0 without special action.
- Branch to the address currently in flight: still flushes and re-fetches; no duplicate instruction is delivered.
- Reset asserted mid-stall or mid-branch: all state clears immediately; no partial update on the following edge.

Test Plan:
- Reset then run: mem[0..3]=1111,2222,3333,4444; release rst, no stall/branch.
  -> Edge 2 IF/ID = (1111, pc 0, pc+1 1, valid 1); edges 3–5 give 2222/3333/4444 with pc 1/2/3; fetch_count=4 after edge 5.
- Stall: assert stall for 3 cycles while IF/ID=(2222, pc 1).
  -> IF/ID holds 2222/pc 1 and imem_addr=2 during stall; first edge after release gives 3333/pc 2; no skip or duplicate; fetch_count unchanged during stall.
- Branch: branch_taken=1, branch_target=0x0040 while IF/ID holds pc 2.
  -> Next edge ifid_valid=0; the following edge IF/ID = (mem[0x40], pc 0x40, valid 1); pc then 0x41, 0x42.
- Branch and stall in the same cycle: stall=1, branch_taken=1, target=0x10.
  -> Branch wins; imem_addr=0x10 that cycle; ifid_valid=0 next edge; mem[0x10] delivered the edge after.
- Wrap and reset mid-run: RESET_PC=16'hFFFE.
  -> Delivered PCs are FFFE, FFFF, 0000 with ifid_pc_plus1 FFFF, 0000, 0001; pulling rst low between edges clears ifid_valid and fetch_count immediately (asynchronously).
- Saturation: force 70000 deliveries (or preload).
  -> fetch_count stops at 16'hFFFF and does not wrap.
